// File: rtl/mesh_streamer_if.sv
// Bundle of all signals between mesh_streamer and its neighbours:
// frame control, the three mesh ROM ports and the triangle FIFO write side.
interface mesh_streamer_if;
    logic         start_in;
    logic [12:0]  triangle_count_in;
    logic         consumed_in;
    logic [14:0]  index_addr_out;
    logic [12:0]  index_data_in;
    logic [12:0]  vertex_addr_out;
    logic [95:0]  vertex_data_in;
    logic [12:0]  attr_addr_out;
    logic [23:0]  attr_data_in;
    logic         position_valid_out;
    logic [127:0] position_out;
    logic         normal_valid_out;
    logic [11:0]  normal_out;
    logic         material_valid_out;
    logic [11:0]  material_out;
    logic         busy_out;
    logic         done_out;

    // The streamer drives addresses and FIFO writes
    modport master (
        input  start_in, triangle_count_in, consumed_in,
        input  index_data_in, vertex_data_in, attr_data_in,
        output index_addr_out, vertex_addr_out, attr_addr_out,
        output position_valid_out, position_out,
        output normal_valid_out, normal_out,
        output material_valid_out, material_out,
        output busy_out, done_out
    );

    // ROMs, FIFO and frame controller see the mirror image
    modport slave (
        output start_in, triangle_count_in, consumed_in,
        output index_data_in, vertex_data_in, attr_data_in,
        input  index_addr_out, vertex_addr_out, attr_addr_out,
        input  position_valid_out, position_out,
        input  normal_valid_out, normal_out,
        input  material_valid_out, material_out,
        input  busy_out, done_out
    );
endinterface

// File: rtl/mesh_streamer.sv
// Walks an indexed triangle mesh (index ROM -> vertex ROM, plus per-triangle
// attribute ROM) and writes one vertex per cycle into the triangle FIFO.
// A credit counter mirrors free FIFO space because the FIFO cannot refuse.
module mesh_streamer #(
    parameter int FIFO_DEPTH  = 8192,
    parameter int ROM_LATENCY = 2
) (
    input logic             clk_in,
    input logic             rst_in,
    mesh_streamer_if.master bus
);
    // Token stage k is valid in cycle t+1+k for an issue in cycle t.
    // Stage ROM_LATENCY-1 sees index data, stage LAST sees vertex/attr data.
    localparam int          LAST       = 2 * ROM_LATENCY;
    localparam logic [13:0] CREDIT_MAX = 14'(FIFO_DEPTH);
    localparam logic [31:0] W_ONE      = 32'h3F80_0000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t       state_q;
    logic [12:0]  count_q;
    logic [12:0]  tri_cnt_q;
    logic [1:0]   corner_q;
    logic [14:0]  idx_cnt_q;
    logic         busy_q;
    logic         done_q;

    logic [13:0]  credits_q,  credits_d;
    logic [LAST:0] vld_q,     vld_d;
    logic [12:0]  tri_q [ROM_LATENCY];
    logic [12:0]  tri_d [ROM_LATENCY];
    logic [14:0]  idx_hold_q, idx_hold_d;
    logic [12:0]  vaddr_q,    vaddr_d;
    logic [12:0]  aaddr_q,    aaddr_d;
    logic         out_vld_q,  out_vld_d;
    logic [127:0] pos_q,      pos_d;
    logic [11:0]  nrm_q,      nrm_d;
    logic [11:0]  mat_q,      mat_d;

    logic issue;
    logic pipe_empty;

    assign issue      = (state_q == S_RUN) && (credits_q != 14'd0);
    assign pipe_empty = (vld_q == '0);

    // Frame sequencing: state, triangle/corner walk, running index address
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            tri_cnt_q <= '0;
            corner_q  <= '0;
            idx_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_in) begin
                        count_q   <= bus.triangle_count_in;
                        tri_cnt_q <= '0;
                        corner_q  <= '0;
                        idx_cnt_q <= '0;
                        if (bus.triangle_count_in == 13'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        idx_cnt_q <= idx_cnt_q + 15'd1;
                        if (corner_q == 2'd2) begin
                            corner_q  <= '0;
                            tri_cnt_q <= tri_cnt_q + 13'd1;
                            if (tri_cnt_q == count_q - 13'd1) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            corner_q <= corner_q + 2'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Credit bookkeeping; a consume at full credit has no entry to return
    always_comb begin
        credits_d = credits_q;
        if (issue && !bus.consumed_in) begin
            credits_d = credits_q - 14'd1;
        end else if (!issue && bus.consumed_in && (credits_q < CREDIT_MAX)) begin
            credits_d = credits_q + 14'd1;
        end
    end

    // Token pipeline and ROM data capture; registers hold between tokens
    always_comb begin
        vld_d      = {vld_q[LAST-1:0], issue};
        idx_hold_d = issue ? idx_cnt_q : idx_hold_q;
        tri_d[0]   = issue ? tri_cnt_q : tri_q[0];
        for (int k = 1; k < ROM_LATENCY; k++) begin
            tri_d[k] = tri_q[k-1];
        end
        vaddr_d   = vaddr_q;
        aaddr_d   = aaddr_q;
        if (vld_q[ROM_LATENCY-1]) begin
            vaddr_d = bus.index_data_in;
            aaddr_d = tri_q[ROM_LATENCY-1];
        end
        out_vld_d = vld_q[LAST];
        pos_d     = pos_q;
        nrm_d     = nrm_q;
        mat_d     = mat_q;
        if (vld_q[LAST]) begin
            pos_d = {W_ONE, bus.vertex_data_in};
            nrm_d = bus.attr_data_in[23:12];
            mat_d = bus.attr_data_in[11:0];
        end
    end

    // Register stage for credits, tokens, addresses and FIFO write outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            credits_q  <= CREDIT_MAX;
            vld_q      <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                tri_q[k] <= '0;
            end
            idx_hold_q <= '0;
            vaddr_q    <= '0;
            aaddr_q    <= '0;
            out_vld_q  <= 1'b0;
            pos_q      <= '0;
            nrm_q      <= '0;
            mat_q      <= '0;
        end else begin
            credits_q  <= credits_d;
            vld_q      <= vld_d;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                tri_q[k] <= tri_d[k];
            end
            idx_hold_q <= idx_hold_d;
            vaddr_q    <= vaddr_d;
            aaddr_q    <= aaddr_d;
            out_vld_q  <= out_vld_d;
            pos_q      <= pos_d;
            nrm_q      <= nrm_d;
            mat_q      <= mat_d;
        end
    end

    assign bus.index_addr_out     = issue ? idx_cnt_q : idx_hold_q;
    assign bus.vertex_addr_out    = vaddr_q;
    assign bus.attr_addr_out      = aaddr_q;
    assign bus.position_valid_out = out_vld_q;
    assign bus.normal_valid_out   = out_vld_q;
    assign bus.material_valid_out = out_vld_q;
    assign bus.position_out       = pos_q;
    assign bus.normal_out         = nrm_q;
    assign bus.material_out       = mat_q;
    assign bus.busy_out           = busy_q;
    assign bus.done_out           = done_q;
endmodule

// File: tb/tb_mesh_streamer.sv
// Directed bench for mesh_streamer: ROM models with 2-cycle latency,
// one full-size instance and one FIFO_DEPTH=4 instance for credit stalls.
module tb_mesh_streamer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mesh_streamer_if bus();
    mesh_streamer_if bus4();

    mesh_streamer #(.FIFO_DEPTH(8192), .ROM_LATENCY(2)) dut (
        .clk_in(clk), .rst_in(rst), .bus(bus)
    );
    mesh_streamer #(.FIFO_DEPTH(4), .ROM_LATENCY(2)) dut4 (
        .clk_in(clk), .rst_in(rst), .bus(bus4)
    );

    int cmp = 0;
    int bad = 0;

    function automatic logic [12:0] idx_rom(input logic [14:0] a);
        logic [16:0] t;
        t = {2'b00, a} * 17'd5 + 17'd7;
        return t[12:0];
    endfunction

    function automatic logic [95:0] vtx_rom(input logic [12:0] v);
        logic [31:0] e;
        e = {19'd0, v};
        return {e + 32'h0000_3000, e ^ 32'hA5A5_A5A5, e + 32'h0000_0001};
    endfunction

    function automatic logic [23:0] attr_rom(input logic [12:0] t);
        return {t[11:0] ^ 12'h5A5, t[11:0] + 12'h011};
    endfunction

    logic [12:0] ir1 = '0, ir2 = '0, jr1 = '0, jr2 = '0;
    logic [95:0] vr1 = '0, vr2 = '0, wr1 = '0, wr2 = '0;
    logic [23:0] ar1 = '0, ar2 = '0, br1 = '0, br2 = '0;

    always @(posedge clk) begin
        ir1 <= idx_rom(bus.index_addr_out);   ir2 <= ir1;
        vr1 <= vtx_rom(bus.vertex_addr_out);  vr2 <= vr1;
        ar1 <= attr_rom(bus.attr_addr_out);   ar2 <= ar1;
        jr1 <= idx_rom(bus4.index_addr_out);  jr2 <= jr1;
        wr1 <= vtx_rom(bus4.vertex_addr_out); wr2 <= wr1;
        br1 <= attr_rom(bus4.attr_addr_out);  br2 <= br1;
    end

    assign bus.index_data_in   = ir2;
    assign bus.vertex_data_in  = vr2;
    assign bus.attr_data_in    = ar2;
    assign bus4.index_data_in  = jr2;
    assign bus4.vertex_data_in = wr2;
    assign bus4.attr_data_in   = br2;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp++;
        if ({bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out} !== 3'b000) begin
            bad++; $display("FAIL reset_valids: got %b expected 000",
                {bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out});
        end
        cmp++;
        if (bus.position_out !== 128'd0 || bus.index_addr_out !== 15'd0) begin
            bad++; $display("FAIL reset_data: got pos %0h idx %0h expected 0", bus.position_out, bus.index_addr_out);
        end
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
            bad++; $display("FAIL reset_busy_done: got %b%b expected 00", bus.busy_out, bus.done_out);
        end
        cmp++;
        if (dut.credits_q !== 14'd8192) begin
            bad++; $display("FAIL reset_credits: got %0d expected 8192", dut.credits_q);
        end
        cmp++;
        if (dut4.credits_q !== 14'd4) begin
            bad++; $display("FAIL reset_credits4: got %0d expected 4", dut4.credits_q);
        end
    endtask

    // start in cycle 0; sample at the negedge of cycle k
    task automatic test_single();
        logic [12:0]  ei;
        logic [127:0] ep;
        logic [23:0]  ea;
        logic         ev;
        ea = attr_rom(13'd0);
        @(negedge clk);
        bus.triangle_count_in = 13'd1;
        bus.start_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_in = 1'b0;
            if (k >= 1 && k <= 3) begin
                cmp++;
                if (bus.index_addr_out !== 15'(k - 1)) begin
                    bad++; $display("FAIL single_index_addr c%0d: got %0d expected %0d", k, bus.index_addr_out, k - 1);
                end
            end
            if (k >= 4 && k <= 6) begin
                ei = idx_rom(15'(k - 4));
                cmp++;
                if (bus.vertex_addr_out !== ei || bus.attr_addr_out !== 13'd0) begin
                    bad++; $display("FAIL single_vtx_addr c%0d: got %0h/%0h expected %0h/0", k,
                        bus.vertex_addr_out, bus.attr_addr_out, ei);
                end
            end
            ev = (k >= 7 && k <= 9);
            cmp++;
            if ({bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out} !== {3{ev}}) begin
                bad++; $display("FAIL single_valids c%0d: got %b expected %b", k,
                    {bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out}, {3{ev}});
            end
            if (ev) begin
                ei = idx_rom(15'(k - 7));
                ep = {32'h3F80_0000, vtx_rom(ei)};
                cmp++;
                if (bus.position_out !== ep) begin
                    bad++; $display("FAIL single_position c%0d: got %0h expected %0h", k, bus.position_out, ep);
                end
                cmp++;
                if (bus.normal_out !== ea[23:12] || bus.material_out !== ea[11:0]) begin
                    bad++; $display("FAIL single_attr c%0d: got %0h/%0h expected %0h/%0h", k,
                        bus.normal_out, bus.material_out, ea[23:12], ea[11:0]);
                end
            end
            cmp++;
            if (bus.done_out !== (k == 10)) begin
                bad++; $display("FAIL single_done c%0d: got %b expected %b", k, bus.done_out, (k == 10));
            end
            if (k <= 9 || k == 11) begin
                cmp++;
                if (bus.busy_out !== (k <= 9)) begin
                    bad++; $display("FAIL single_busy c%0d: got %b expected %b", k, bus.busy_out, (k <= 9));
                end
            end
        end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        bus.triangle_count_in = 13'd0;
        bus.start_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_in = 1'b0;
            cmp++;
            if (bus.position_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.index_addr_out !== 15'd2) begin
                bad++; $display("FAIL zero_quiet c%0d: got v%b b%b idx %0d expected v0 b0 idx 2", k,
                    bus.position_valid_out, bus.busy_out, bus.index_addr_out);
            end
            cmp++;
            if (bus.done_out !== (k == 1)) begin
                bad++; $display("FAIL zero_done c%0d: got %b expected %b", k, bus.done_out, (k == 1));
            end
        end
    endtask

    task automatic test_credit_stall();
        int  pulses;
        int  late;
        logic seen_done;
        pulses = 0;
        @(negedge clk);
        bus4.triangle_count_in = 13'd3;
        bus4.start_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) bus4.start_in = 1'b0;
            if (bus4.position_valid_out) pulses++;
        end
        cmp++;
        if (pulses != 4) begin
            bad++; $display("FAIL stall_first_burst: got %0d pulses expected 4", pulses);
        end
        cmp++;
        if (bus4.busy_out !== 1'b1 || bus4.done_out !== 1'b0) begin
            bad++; $display("FAIL stall_busy: got busy %b done %b expected 1 0", bus4.busy_out, bus4.done_out);
        end
        @(negedge clk);
        bus4.consumed_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus4.consumed_in = 1'b0;
            if (bus4.position_valid_out) pulses++;
            cmp++;
            if (bus4.position_valid_out !== (k == 7)) begin
                bad++; $display("FAIL stall_one_credit c%0d: got %b expected %b", k, bus4.position_valid_out, (k == 7));
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus4.consumed_in = 1'b1;
            if (bus4.position_valid_out) pulses++;
        end
        seen_done = 1'b0;
        late = 0;
        for (int k = 1; k <= 40 && !seen_done; k++) begin
            @(negedge clk);
            if (k == 1) bus4.consumed_in = 1'b0;
            if (bus4.position_valid_out) begin pulses++; late++; end
            if (bus4.done_out) seen_done = 1'b1;
        end
        cmp++;
        if (!seen_done) begin
            bad++; $display("FAIL stall_done_timeout: got no done within 40 cycles expected done");
        end
        cmp++;
        if (pulses != 9 || late != 4) begin
            bad++; $display("FAIL stall_total: got %0d total %0d tail expected 9 total 4 tail", pulses, late);
        end
        cmp++;
        if (dut4.credits_q !== 14'd0) begin
            bad++; $display("FAIL stall_credits_end: got %0d expected 0", dut4.credits_q);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, first, last, done_k;
        logic [14:0] maxi;
        pulses = 0; first = -1; last = -1; done_k = -1; maxi = '0;
        bus.consumed_in = 1'b1;
        repeat (20) @(negedge clk);
        bus.triangle_count_in = 13'd3000;
        bus.start_in = 1'b1;
        for (int k = 1; k <= 9100 && done_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_in = 1'b0;
            if (bus.position_valid_out) begin
                pulses++;
                if (first < 0) first = k;
                last = k;
            end
            if (bus.index_addr_out > maxi) maxi = bus.index_addr_out;
            if (bus.done_out) done_k = k;
            if (k >= 100 && k < 120) begin
                cmp++;
                if (dut.credits_q !== 14'd8192) begin
                    bad++; $display("FAIL stream_credits c%0d: got %0d expected 8192", k, dut.credits_q);
                end
            end
        end
        bus.consumed_in = 1'b0;
        cmp++;
        if (pulses != 9000) begin
            bad++; $display("FAIL stream_pulses: got %0d expected 9000", pulses);
        end
        cmp++;
        if (first != 7 || last - first + 1 != 9000) begin
            bad++; $display("FAIL stream_gapless: got first %0d span %0d expected first 7 span 9000", first, last - first + 1);
        end
        cmp++;
        if (maxi !== 15'd8999) begin
            bad++; $display("FAIL stream_max_index: got %0d expected 8999", maxi);
        end
        cmp++;
        if (done_k != last + 1) begin
            bad++; $display("FAIL stream_done_cycle: got %0d expected %0d", done_k, last + 1);
        end
    endtask

    task automatic test_start_ignored();
        int   pulses;
        logic seen_done;
        pulses = 0; seen_done = 1'b0;
        @(negedge clk);
        bus.triangle_count_in = 13'd4;
        bus.start_in = 1'b1;
        for (int k = 1; k <= 60 && !seen_done; k++) begin
            @(negedge clk);
            bus.start_in = (k == 3);
            if (k == 3) bus.triangle_count_in = 13'd1;
            if (bus.position_valid_out) pulses++;
            if (bus.done_out) seen_done = 1'b1;
        end
        bus.start_in = 1'b0;
        cmp++;
        if (!seen_done || pulses != 12) begin
            bad++; $display("FAIL start_ignored: got done %b pulses %0d expected done 1 pulses 12", seen_done, pulses);
        end
        repeat (3) @(negedge clk);
        cmp++;
        if (bus.busy_out !== 1'b0) begin
            bad++; $display("FAIL start_ignored_idle: got busy %b expected 0", bus.busy_out);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bus.triangle_count_in = 13'd10;
        bus.start_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_in = 1'b0;
        end
        cmp++;
        if (bus.position_valid_out !== 1'b1) begin
            bad++; $display("FAIL areset_precondition: got valid %b expected 1", bus.position_valid_out);
        end
        #2 rst = 1'b1;
        #1;
        cmp++;
        if ({bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out, bus.busy_out, bus.done_out} !== 5'b0) begin
            bad++; $display("FAIL areset_ctrl: got %b expected 00000",
                {bus.position_valid_out, bus.normal_valid_out, bus.material_valid_out, bus.busy_out, bus.done_out});
        end
        cmp++;
        if (bus.position_out !== 128'd0 || bus.normal_out !== 12'd0 || bus.material_out !== 12'd0 ||
            bus.index_addr_out !== 15'd0 || bus.vertex_addr_out !== 13'd0 || bus.attr_addr_out !== 13'd0) begin
            bad++; $display("FAIL areset_data: got pos %0h idx %0h vaddr %0h expected 0",
                bus.position_out, bus.index_addr_out, bus.vertex_addr_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.position_valid_out) pulses++;
        end
        cmp++;
        if (pulses != 0) begin
            bad++; $display("FAIL areset_no_pulses: got %0d expected 0", pulses);
        end
        cmp++;
        if (dut.credits_q !== 14'd8192) begin
            bad++; $display("FAIL areset_credits: got %0d expected 8192", dut.credits_q);
        end
        test_single();
    endtask

    initial begin
        bus.start_in = 1'b0;  bus.triangle_count_in = '0;  bus.consumed_in = 1'b0;
        bus4.start_in = 1'b0; bus4.triangle_count_in = '0; bus4.consumed_in = 1'b0;
        #2;
        test_reset();
        test_single();
        test_zero_count();
        test_credit_stall();
        test_back_to_back();
        test_start_ignored();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/mesh_streamer.md
# mesh_streamer

Front-end producer for the triangle FIFO: walks an indexed mesh held in three external ROMs and emits one vertex per cycle as position, normal and material write pulses. The FIFO has no overflow protection, so this block owns flow control with a credit counter returned by the FIFO's read handshake. It sits between the scene/model ROMs and the triangle FIFO, ahead of the vertex transform stage.

## Interface
Parameters:
- FIFO_DEPTH, 8192: downstream FIFO entries; initial and maximum credit count.
- ROM_LATENCY, 2: fixed read latency of all three ROM ports. Design is verified at 2 only.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- start_in  input  1  pulse; begins a frame when idle
- triangle_count_in  input  13  triangles in frame, sampled with start_in
- consumed_in  input  1  one FIFO entry consumed (FIFO valid && ready)
- index_addr_out  output  15  index ROM address (3*triangle + corner)
- index_data_in  input  13  vertex index
- vertex_addr_out  output  13  vertex ROM address
- vertex_data_in  input  96  {z, y, x} fp32
- attr_addr_out  output  13  attribute ROM address (triangle number)
- attr_data_in  input  24  {normal[11:0], material[11:0]}
- position_valid_out  output  1  position write pulse
- position_out  output  4x32  {w, z, y, x}; w fixed 32'h3F800000
- normal_valid_out  output  1  normal write pulse
- normal_out  output  12  normal
- material_valid_out  output  1  material write pulse
- material_out  output  12  material
- busy_out  output  1  frame in progress
- done_out  output  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start_in latches triangle_count_in, clears triangle and corner counters, enters RUN. If count is 0, enters DONE instead. start_in in any other state is ignored.
- RUN: one vertex is issued per cycle when credits > 0. Issue presents index_addr_out, decrements credits, and pushes a valid token with its triangle number into the pipeline. Corner counts 0,1,2; the triangle increments on corner 2. index_addr_out is a running counter, not a multiply. After corner 2 of triangle count-1 is issued, go to DRAIN.
- DRAIN: no issue; wait until the pipeline is empty, then go to DONE.
- DONE: done_out=1 for one cycle, then go to IDLE.
- Credits: 14-bit counter, reset to FIFO_DEPTH. Issue decrements it and consumed_in increments it; both in one cycle leave it unchanged. Credits persist across frames. consumed_in at FIFO_DEPTH is ignored (saturate).
- All three valid outputs assert in the same cycle; each pulse is one FIFO entry.
- busy_out = state is RUN or DRAIN.

## Timing
- Issue in cycle t: index_addr_out valid in t; index_data_in sampled end of t+2.
- vertex_addr_out = registered index, and attr_addr_out = triangle number, both valid in t+3. Data sampled end of t+5.
- Outputs are registered and valid in cycle t+6. Issue-to-pulse latency is 6; throughput is 1 vertex/cycle with no bubbles while credits last.
- Address outputs hold their last value when not issuing. ROM ports are always enabled.
- done_out asserts in the cycle after the last valid pulse.
- Reset (async): state IDLE, credits FIFO_DEPTH, pipeline tokens cleared, all valids/busy_out/done_out 0, all data/address outputs 0. Reset mid-frame discards in-flight vertices; no pulse follows deassertion.

## Test plan
- Single triangle, full credits: start, count=1. index_addr 0,1,2 in cycles 1-3. Three consecutive triple-valid pulses in cycles 7-9 with w=3F800000, ROM-modelled xyz, identical normal/material. done_out in cycle 10, busy_out low in cycle 11.
- Zero count: start with count=0. No addresses issued, no valids, done_out the cycle after DONE entry, busy_out never high.
- Credit stall: FIFO_DEPTH=4, count=3, no consumed_in. Exactly 4 pulses, then stall. One consumed_in pulse yields exactly one more vertex, 7 cycles later. Completes after 9 total.
- Simultaneous issue and consumed_in over 20 cycles: credit count is constant. 3000-triangle frame streams 9000 pulses with no gaps. Index address reaches 8999.
- Async reset asserted mid-frame between edges: outputs go to 0 immediately, no pulses after release, credits equal FIFO_DEPTH, next start runs normally.
- start_in pulsed during RUN with a different count: ignored; the original frame completes with its original vertex count.
